// File: rtl/sd_pkg.sv
// Shared types and constants for the SD DAT0 block reader.
package sd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_READ_DAT,
      ST_READ_CRC,
      ST_READ_END
   } rd_state_t;

   localparam int unsigned BLOCK_BYTES_DEF = 512;
   localparam int unsigned ADDR_W          = 9;
   localparam int unsigned CRC16_W         = 16;
   localparam logic [CRC16_W-1:0] CRC16_POLY = 16'h1021;
   localparam logic START_BIT = 1'b0;
   localparam logic END_BIT   = 1'b1;

   // One serial step of CRC16-CCITT (x^16+x^12+x^5+1), MSB first.
   function automatic logic [CRC16_W-1:0] crc16_step(input logic [CRC16_W-1:0] crc,
                                                     input logic din);
      logic fb;
      fb = crc[CRC16_W-1] ^ din;
      return {crc[CRC16_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
   endfunction

endpackage

// File: rtl/sd_crc_16.sv
// Bit-serial CRC16 accumulator; advances one bit per enabled clk.
module sd_crc_16
   import sd_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               en,
   input  logic               din,
   output logic [CRC16_W-1:0] crc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc <= '0;
      end else if (clear) begin
         crc <= '0;
      end else if (en) begin
         crc <= crc16_step(crc, din);
      end
   end

endmodule

// File: rtl/sd_block_reader.sv
// Receives one SD data block on DAT0: start bit, BLOCK_BYTES bytes, CRC16, end bit.
// Bytes are emitted through a write strobe; status is reported with a done pulse.
module sd_block_reader
   import sd_pkg::*;
#(
   parameter int unsigned TIMEOUT     = 1000000,
   parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sdclk,
   input  logic              sddat0,
   input  logic              rstart,
   output logic              rbusy,
   output logic              rdone,
   output logic              rerr,
   output logic              rtimeout,
   output logic [7:0]        rbyte,
   output logic [ADDR_W-1:0] raddr,
   output logic              rwe,
   output logic              D0_DIR
);

   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] BYTE_LAST = ADDR_W'(BLOCK_BYTES - 1);

   rd_state_t            state;
   logic                 sdclk_q;
   logic [3:0]           bit_cnt;
   logic [ADDR_W-1:0]    byte_cnt;
   logic [TO_W-1:0]      to_cnt;
   logic [6:0]           shreg;
   logic [CRC16_W-1:0]   crc_rx;
   logic [CRC16_W-1:0]   crc_calc;
   logic                 tick_c;
   logic                 arm_c;
   logic                 crc_en_c;

   // A tick is a rising sdclk seen through the registered copy.
   assign tick_c   = ~sdclk_q & sdclk;
   // A start request landing on the done pulse must not re-arm.
   assign arm_c    = (state == ST_IDLE) & rstart & ~rdone;
   assign crc_en_c = tick_c & (state == ST_READ_DAT);

   assign D0_DIR = 1'b0;

   sd_crc_16 u_crc (
      .clk   (clk),
      .rst   (rst),
      .clear (arm_c),
      .en    (crc_en_c),
      .din   (sddat0),
      .crc   (crc_calc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         sdclk_q  <= 1'b0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         to_cnt   <= '0;
         shreg    <= '0;
         crc_rx   <= '0;
         rbusy    <= 1'b0;
         rdone    <= 1'b0;
         rerr     <= 1'b0;
         rtimeout <= 1'b0;
         rwe      <= 1'b0;
         rbyte    <= '0;
         raddr    <= '0;
      end else begin
         sdclk_q <= sdclk;
         rdone   <= 1'b0;
         rwe     <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (arm_c) begin
                  bit_cnt  <= '0;
                  byte_cnt <= '0;
                  to_cnt   <= '0;
                  crc_rx   <= '0;
                  rerr     <= 1'b0;
                  rtimeout <= 1'b0;
                  rbusy    <= 1'b1;
                  state    <= ST_WAIT_START;
               end
            end

            ST_WAIT_START: begin
               if (tick_c) begin
                  if (sddat0 == START_BIT) begin
                     bit_cnt <= '0;
                     state   <= ST_READ_DAT;
                  end else if (to_cnt == TO_LAST) begin
                     rdone    <= 1'b1;
                     rerr     <= 1'b1;
                     rtimeout <= 1'b1;
                     rbusy    <= 1'b0;
                     state    <= ST_IDLE;
                  end else begin
                     to_cnt <= to_cnt + TO_W'(1);
                  end
               end
            end

            ST_READ_DAT: begin
               if (tick_c) begin
                  shreg <= {shreg[5:0], sddat0};
                  if (bit_cnt == 4'd7) begin
                     rbyte   <= {shreg, sddat0};
                     raddr   <= byte_cnt;
                     rwe     <= 1'b1;
                     bit_cnt <= '0;
                     if (byte_cnt == BYTE_LAST) begin
                        state <= ST_READ_CRC;
                     end else begin
                        byte_cnt <= byte_cnt + ADDR_W'(1);
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end

            // Received CRC is only captured; the accumulator is frozen here.
            ST_READ_CRC: begin
               if (tick_c) begin
                  crc_rx <= {crc_rx[CRC16_W-2:0], sddat0};
                  if (bit_cnt == 4'd15) begin
                     bit_cnt <= '0;
                     state   <= ST_READ_END;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end

            ST_READ_END: begin
               if (tick_c) begin
                  rdone    <= 1'b1;
                  rerr     <= (crc_rx != crc_calc) || (sddat0 != END_BIT);
                  rtimeout <= 1'b0;
                  rbusy    <= 1'b0;
                  state    <= ST_IDLE;
               end
            end

            default: begin
               rbusy <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_block_reader.sv
// Self-checking bench for sd_block_reader driving a modelled card on DAT0.
module tb_sd_block_reader;

   localparam int unsigned TO = 100;
   localparam int unsigned NB = 512;

   logic       clk = 1'b0;
   logic       rst;
   logic       sdclk;
   logic       sddat0;
   logic       rstart;
   logic       rbusy;
   logic       rdone;
   logic       rerr;
   logic       rtimeout;
   logic [7:0] rbyte;
   logic [8:0] raddr;
   logic       rwe;
   logic       d0_dir;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;

   logic [7:0]  blk [NB];
   logic [16:0] wq [$];

   always #5 clk = ~clk;

   sd_block_reader #(.TIMEOUT(TO), .BLOCK_BYTES(NB)) dut (
      .clk      (clk),
      .rst      (rst),
      .sdclk    (sdclk),
      .sddat0   (sddat0),
      .rstart   (rstart),
      .rbusy    (rbusy),
      .rdone    (rdone),
      .rerr     (rerr),
      .rtimeout (rtimeout),
      .rbyte    (rbyte),
      .raddr    (raddr),
      .rwe      (rwe),
      .D0_DIR   (d0_dir)
   );

   // Record every write strobe and done pulse away from the active edge.
   always @(negedge clk) begin
      if (rwe) wq.push_back({raddr, rbyte});
      if (rdone) done_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   // CRC16-CCITT of the first n block bytes as a polynomial remainder, MSB first.
   function automatic logic [15:0] model_crc(input int n);
      logic [15:0] c;
      logic        m;
      c = 16'h0000;
      for (int i = 0; i < n; i++) begin
         for (int k = 7; k >= 0; k--) begin
            m = c[15] ^ blk[i][k];
            c = {c[14:0], 1'b0};
            if (m) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   // Index of the first recorded write that differs from the block, or -1.
   function automatic int first_bad(input int n);
      for (int i = 0; i < n && i < wq.size(); i++)
         if (wq[i] !== {9'(i), blk[i]}) return i;
      return -1;
   endfunction

   task automatic send_bit(input logic b);
      @(negedge clk);
      sdclk  = 1'b0;
      sddat0 = b;
      @(negedge clk);
      sdclk  = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int k = 7; k >= 0; k--) send_bit(v[k]);
   endtask

   task automatic pulse_rstart();
      @(negedge clk);
      rstart = 1'b1;
      @(negedge clk);
      rstart = 1'b0;
   endtask

   task automatic arm();
      wq.delete();
      pulse_rstart();
   endtask

   // Card side: idle ones, start bit, data, then optionally CRC and end bit.
   task automatic send_block(input int pre, input int nbytes, input int hook,
                             input logic [15:0] crc, input logic endb, input logic tail);
      for (int i = 0; i < pre; i++) send_bit(1'b1);
      send_bit(1'b0);
      for (int b = 0; b < nbytes; b++) begin
         if (b == hook) begin
            pulse_rstart();
            repeat (25) @(negedge clk);
            pulse_rstart();
            repeat (25) @(negedge clk);
         end
         send_byte(blk[b]);
      end
      if (tail) begin
         for (int k = 15; k >= 0; k--) send_bit(crc[k]);
         send_bit(endb);
      end
   endtask

   task automatic fill_pattern();
      for (int i = 0; i < NB; i++) blk[i] = 8'(i);
   endtask

   task automatic fill_random();
      for (int i = 0; i < NB; i++) blk[i] = 8'($urandom);
   endtask

   task automatic test_reset();
      logic [22:0] obs;
      rst = 1'b1; rstart = 1'b0; sdclk = 1'b0; sddat0 = 1'b1;
      repeat (3) @(negedge clk);
      obs = {rbusy, rdone, rerr, rtimeout, rwe, d0_dir, rbyte, raddr};
      checks++;
      if (obs !== 23'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected %h", obs, 23'd0);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (rbusy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_busy: got %b expected 0", rbusy);
      end
   endtask

   task automatic test_good_block();
      logic [15:0] c;
      int bad;
      fill_pattern();
      c = model_crc(NB);
      arm();
      checks++;
      if (rbusy !== 1'b1) begin
         failures++;
         $display("FAIL good_busy_after_arm: got %b expected 1", rbusy);
      end
      send_block(int'($urandom_range(20, 0)), NB, -1, c, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if ({rdone, rerr, rtimeout, rbusy} !== 4'b1000) begin
         failures++;
         $display("FAIL good_done_status: got done/err/to/busy %b expected 1000",
                  {rdone, rerr, rtimeout, rbusy});
      end
      checks++;
      if (wq.size() !== NB) begin
         failures++;
         $display("FAIL good_write_count: got %0d expected %0d", wq.size(), NB);
      end
      bad = first_bad(NB);
      checks++;
      if (bad !== -1) begin
         failures++;
         $display("FAIL good_stream: entry %0d got %h expected %h", bad, wq[bad], {9'(bad), blk[bad]});
      end
      @(negedge clk);
      checks++;
      if (rdone !== 1'b0) begin
         failures++;
         $display("FAIL good_done_one_shot: got %b expected 0", rdone);
      end
   endtask

   task automatic test_crc_error();
      logic [15:0] c;
      int bad;
      fill_pattern();
      c = model_crc(NB) ^ 16'h0001;
      arm();
      send_block(int'($urandom_range(20, 0)), NB, -1, c, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if ({rdone, rerr, rtimeout} !== 3'b110) begin
         failures++;
         $display("FAIL crc_done_status: got done/err/to %b expected 110", {rdone, rerr, rtimeout});
      end
      bad = first_bad(NB);
      checks++;
      if (wq.size() !== NB || bad !== -1) begin
         failures++;
         $display("FAIL crc_stream: got %0d writes first bad %0d expected %0d writes none bad",
                  wq.size(), bad, NB);
      end
   endtask

   task automatic test_timeout();
      int d0;
      arm();
      d0 = done_cnt;
      repeat (TO) send_bit(1'b1);
      checks++;
      if (done_cnt !== d0 || rdone !== 1'b0) begin
         failures++;
         $display("FAIL timeout_early: got %0d done pulses before tick %0d expected 0",
                  done_cnt - d0, TO);
      end
      @(negedge clk);
      checks++;
      if ({rdone, rerr, rtimeout, rbusy} !== 4'b1110) begin
         failures++;
         $display("FAIL timeout_status: got done/err/to/busy %b expected 1110",
                  {rdone, rerr, rtimeout, rbusy});
      end
      repeat (5) send_bit(1'b1);
      @(negedge clk);
      checks++;
      if ({rerr, rtimeout} !== 2'b11 || done_cnt !== d0 + 1 || wq.size() !== 0) begin
         failures++;
         $display("FAIL timeout_hold: got err/to %b done pulses %0d writes %0d expected 11 1 0",
                  {rerr, rtimeout}, done_cnt - d0, wq.size());
      end
   endtask

   task automatic test_end_bit();
      logic [15:0] c;
      fill_random();
      c = model_crc(NB);
      arm();
      checks++;
      if ({rerr, rtimeout} !== 2'b00) begin
         failures++;
         $display("FAIL endbit_status_cleared: got err/to %b expected 00", {rerr, rtimeout});
      end
      send_block(int'($urandom_range(20, 0)), NB, -1, c, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if ({rdone, rerr, rtimeout} !== 3'b110) begin
         failures++;
         $display("FAIL endbit_status: got done/err/to %b expected 110", {rdone, rerr, rtimeout});
      end
      checks++;
      if (wq.size() !== NB || first_bad(NB) !== -1) begin
         failures++;
         $display("FAIL endbit_stream: got %0d writes first bad %0d expected %0d clean",
                  wq.size(), first_bad(NB), NB);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] c;
      int d0;
      fill_random();
      arm();
      d0 = done_cnt;
      send_block(int'($urandom_range(20, 0)), 201, -1, 16'h0000, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({rbusy, rwe, rdone} !== 3'b000) begin
         failures++;
         $display("FAIL rstmid_abort: got busy/we/done %b expected 000", {rbusy, rwe, rdone});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) send_bit(1'($urandom));
      @(negedge clk);
      checks++;
      if (wq.size() !== 201 || first_bad(201) !== -1 || done_cnt !== d0) begin
         failures++;
         $display("FAIL rstmid_partial: got %0d writes first bad %0d done %0d expected 201 clean 0",
                  wq.size(), first_bad(201), done_cnt - d0);
      end
      fill_random();
      c = model_crc(NB);
      arm();
      send_block(int'($urandom_range(20, 0)), NB, -1, c, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if ({rdone, rerr, rtimeout} !== 3'b100) begin
         failures++;
         $display("FAIL rstmid_fresh_status: got done/err/to %b expected 100", {rdone, rerr, rtimeout});
      end
      checks++;
      if (wq.size() !== NB || first_bad(NB) !== -1) begin
         failures++;
         $display("FAIL rstmid_fresh_stream: got %0d writes first bad %0d expected %0d clean",
                  wq.size(), first_bad(NB), NB);
      end
   endtask

   task automatic test_stall_rearm();
      logic [15:0] c;
      fill_random();
      c = model_crc(NB);
      arm();
      send_block(int'($urandom_range(20, 0)), NB, int'($urandom_range(300, 5)), c, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if ({rdone, rerr, rtimeout} !== 3'b100) begin
         failures++;
         $display("FAIL stall_status: got done/err/to %b expected 100", {rdone, rerr, rtimeout});
      end
      checks++;
      if (wq.size() !== NB || first_bad(NB) !== -1) begin
         failures++;
         $display("FAIL stall_stream: got %0d writes first bad %0d expected %0d clean",
                  wq.size(), first_bad(NB), NB);
      end
      rstart = 1'b1;
      @(negedge clk);
      rstart = 1'b0;
      checks++;
      if (rbusy !== 1'b0) begin
         failures++;
         $display("FAIL rearm_on_done: got busy %b expected 0", rbusy);
      end
   endtask

   initial begin
      test_reset();
      test_good_block();
      test_crc_error();
      test_timeout();
      test_end_bit();
      test_reset_mid();
      test_stall_rearm();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sd_block_reader.md
SD_BLOCK_READER -- requirements
Module: sd_block_reader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000000: sdclk rising edges to wait for the start bit before aborting.
REQ-002 SHALL have parameter BLOCK_BYTES, default 512: data bytes per block.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port sdclk, input, 1 bit: SD clock driven by the command controller; synchronous to clk.
REQ-006 SHALL have port sddat0, input, 1 bit: SD DAT0 line, card to host.
REQ-007 SHALL have port rstart, input, 1 bit: one-clk pulse that arms reception of one block.
REQ-008 SHALL have port rbusy, output, 1 bit: high while the state is not IDLE.
REQ-009 SHALL have port rdone, output, 1 bit: one-clk pulse when the block ends (good, CRC error or timeout).
REQ-010 SHALL have port rerr, output, 1 bit: status qualified by rdone; set for CRC mismatch, bad end bit or timeout.
REQ-011 SHALL have port rtimeout, output, 1 bit: status qualified by rdone; set for start-bit timeout.
REQ-012 SHALL have port rbyte, output, 8 bits: assembled data byte.
REQ-013 SHALL have port raddr, output, 9 bits: byte index 0..BLOCK_BYTES-1 of rbyte.
REQ-014 SHALL have port rwe, output, 1 bit: one-clk write strobe qualifying rbyte/raddr.
REQ-015 SHALL have port D0_DIR, output, 1 bit: DECA DAT0 direction; constant 0 (from card).

Function
REQ-016 SHALL sample sddat0 only on clk cycles where sdclk_q==0 and sdclk==1 (registered edge detect), called a "tick" below.
REQ-017 SHALL implement states IDLE, WAIT_START, READ_DAT, READ_CRC, READ_END.
REQ-018 IDLE: on rstart, SHALL clear the bit counter, byte counter, timeout counter and CRC, then go to WAIT_START; rstart in any other state SHALL be ignored.
REQ-019 WAIT_START: a tick with sddat0==0 SHALL go to READ_DAT; otherwise each tick increments the timeout counter.
REQ-020 WAIT_START: when the timeout counter reaches TIMEOUT, SHALL pulse rdone with rerr=1 and rtimeout=1, then go to IDLE.
REQ-021 READ_DAT: SHALL shift bits MSB-first, one per tick, and feed each bit into the CRC16 (poly x^16+x^12+x^5+1, init 0).
REQ-022 READ_DAT: on the 8th bit of a byte, SHALL present the byte on rbyte and pulse rwe with raddr equal to the byte index, in the clk cycle after that tick.
REQ-023 After byte BLOCK_BYTES-1, SHALL go to READ_CRC; raddr SHALL never exceed BLOCK_BYTES-1.
REQ-024 READ_CRC: SHALL shift 16 bits MSB-first into a receive register without updating the CRC, then go to READ_END.
REQ-025 READ_END: on the next tick, SHALL pulse rdone; rerr = (received CRC != computed CRC) OR (sddat0==0); rtimeout=0; then go to IDLE.
REQ-026 rerr and rtimeout SHALL hold their values until the next rstart.
REQ-027 rstart and rdone in the same cycle SHALL not re-arm the block (no back-to-back arm); re-arming requires IDLE.
REQ-028 Latency from the tick carrying the end bit to rdone SHALL be 1 clk.

Reset
REQ-029 On rst: state=IDLE; rbusy=0, rdone=0, rerr=0, rtimeout=0, rwe=0, rbyte=0, raddr=0, D0_DIR=0, all counters and the CRC cleared, sdclk_q=0.
REQ-030 rst asserted mid-block SHALL abort immediately, with no rdone or rwe produced for the aborted block.

Structure
REQ-031 Package sd_pkg SHALL hold the reader state enum, BLOCK_BYTES default, CRC16 width/polynomial constant and the start/end bit values.
REQ-032 The serial CRC16 SHALL be one sub-module, sd_crc_16 (bit in, enable, clear, 16-bit out), clocked on clk and enabled by the tick.

Verification
REQ-033 Scenario: rstart; card sends start bit, bytes 0x00..0xFF twice, valid CRC, end bit 1 -> 512 rwe pulses with raddr 0..511 and rbyte==raddr[7:0], then rdone=1, rerr=0.
REQ-034 Scenario: same block with CRC bit 0 flipped -> all 512 rwe pulses occur, then rdone=1, rerr=1, rtimeout=0.
REQ-035 Scenario: TIMEOUT=100, DAT0 held high -> rdone on tick 100, rerr=1, rtimeout=1, no rwe pulses.
REQ-036 Scenario: valid block with end bit 0 -> rdone=1, rerr=1.
REQ-037 Scenario: rst asserted after byte 200 -> rbusy=0 next cycle, no further rwe; a new rstart then reads a fresh block starting at raddr=0.
REQ-038 Scenario: rstart pulses during READ_DAT and with sdclk held stalled for 50 clks -> both are ignored and the byte stream is unaffected.
